// File: rtl/vga_pkg.sv
// Shared VGA timing helpers: frame length derivation and sync-window compare.
package vga_pkg;

    function automatic int frame_len(input int res, input int fp, input int pulse, input int bp);
        return res + fp + pulse + bp;
    endfunction

    // True when pos lies in [start, start+len-1]; a zero-length window never matches.
    function automatic logic in_window(input int pos, input int start, input int len);
        return (pos >= start) && (pos < start + len);
    endfunction

endpackage

// File: rtl/vga_test_pattern.sv
// Colour test pattern from beam position and frame count (built only with VGA_VIDEO_GEN_TEST_PICTURE_EN).
// Latency: 1 cycle from beam position to colour.
// Backpressure: none; free-running alongside the beam.
`ifdef VGA_VIDEO_GEN_TEST_PICTURE_EN
module vga_test_pattern #(
    parameter int C_bits_x     = 12,
    parameter int C_bits_y     = 11,
    parameter int C_bits_color = 8
) (
    input  logic                    clk_pixel,
    input  logic                    reset_n,
    input  logic [C_bits_x-1:0]     beam_x,
    input  logic [C_bits_y-1:0]     beam_y,
    input  logic [15:0]             frame_count,
    output logic [C_bits_color-1:0] pat_r,
    output logic [C_bits_color-1:0] pat_g,
    output logic [C_bits_color-1:0] pat_b
);
    logic [C_bits_color-1:0] pat_r_d, pat_g_d, pat_b_d;
    logic [C_bits_color-1:0] pat_r_q, pat_g_q, pat_b_q;

    // Horizontal ramp, vertical ramp and a diagonal pattern that scrolls with the frame count.
    always_comb begin
        pat_r_d = C_bits_color'(beam_x);
        pat_g_d = C_bits_color'(beam_y);
        pat_b_d = C_bits_color'(beam_x ^ C_bits_x'(beam_y)) + C_bits_color'(frame_count);
    end

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            pat_r_q <= '0;
            pat_g_q <= '0;
            pat_b_q <= '0;
        end else begin
            pat_r_q <= pat_r_d;
            pat_g_q <= pat_g_d;
            pat_b_q <= pat_b_d;
        end
    end

    assign pat_r = pat_r_q;
    assign pat_g = pat_g_q;
    assign pat_b = pat_b_q;

endmodule
`endif

// File: rtl/vga_video_gen.sv
// VGA timing generator and pixel pipeline; pops a pixel FIFO and drives colour, syncs and blanking.
// Latency: colour, syncs and blanks appear one cycle after the beam position that produced them.
// Backpressure: none; fetch_next pops the FIFO and its data is expected the following cycle.
// Optional test pattern generator: define VGA_VIDEO_GEN_TEST_PICTURE_EN.
module vga_video_gen
    import vga_pkg::*;
#(
    parameter int C_resolution_x      = 640,
    parameter int C_hsync_front_porch = 16,
    parameter int C_hsync_pulse       = 96,
    parameter int C_hsync_back_porch  = 48,
    parameter int C_resolution_y      = 480,
    parameter int C_vsync_front_porch = 10,
    parameter int C_vsync_pulse       = 2,
    parameter int C_vsync_back_porch  = 33,
    parameter int C_hsync_pol         = 0,
    parameter int C_vsync_pol         = 0,
    parameter int C_dbl_x             = 0,
    parameter int C_dbl_y             = 0,
    parameter int C_bits_x            = 12,
    parameter int C_bits_y            = 11,
    parameter int C_bits_color        = 8
) (
    input  logic                    clk_pixel,
    input  logic                    reset_n,
    input  logic                    test_picture,
    input  logic [C_bits_color-1:0] red_byte,
    input  logic [C_bits_color-1:0] green_byte,
    input  logic [C_bits_color-1:0] blue_byte,
    output logic                    fetch_next,
    output logic                    line_repeat,
    output logic [C_bits_x-1:0]     beam_x,
    output logic [C_bits_y-1:0]     beam_y,
    output logic [15:0]             frame_count,
    output logic                    frame_start,
    output logic [C_bits_color-1:0] vga_r,
    output logic [C_bits_color-1:0] vga_g,
    output logic [C_bits_color-1:0] vga_b,
    output logic                    vga_hsync,
    output logic                    vga_vsync,
    output logic                    vga_vblank,
    output logic                    vga_blank
);
    localparam int FRAME_X  = frame_len(C_resolution_x, C_hsync_front_porch, C_hsync_pulse, C_hsync_back_porch);
    localparam int FRAME_Y  = frame_len(C_resolution_y, C_vsync_front_porch, C_vsync_pulse, C_vsync_back_porch);
    localparam int HS_START = C_resolution_x + C_hsync_front_porch;
    localparam int VS_START = C_resolution_y + C_vsync_front_porch;

    localparam logic [C_bits_x-1:0] X_LAST = C_bits_x'(FRAME_X - 1);
    localparam logic [C_bits_y-1:0] Y_LAST = C_bits_y'(FRAME_Y - 1);
    localparam logic [C_bits_x-1:0] X_RES  = C_bits_x'(C_resolution_x);
    localparam logic [C_bits_y-1:0] Y_RES  = C_bits_y'(C_resolution_y);
    localparam logic                HS_ON  = (C_hsync_pol != 0);
    localparam logic                VS_ON  = (C_vsync_pol != 0);

    typedef struct packed {
        logic [C_bits_color-1:0] r;
        logic [C_bits_color-1:0] g;
        logic [C_bits_color-1:0] b;
    } rgb_t;

    logic [C_bits_x-1:0] cx_q, cx_d;
    logic [C_bits_y-1:0] cy_q, cy_d;
    logic [15:0]         fc_q, fc_d;
    logic                active, hs_win, vs_win, sof;
    logic                active_q, active_d;
    logic                hsync_q, hsync_d;
    logic                vsync_q, vsync_d;
    logic                vblank_q, vblank_d;
    logic                tp_q, tp_d;
    logic                use_pat;
    rgb_t                rgb_q, rgb_d, pat, pix;

    always_comb begin
        active = (cx_q < X_RES) && (cy_q < Y_RES);
        hs_win = in_window(int'(cx_q), HS_START, C_hsync_pulse);
        vs_win = in_window(int'(cy_q), VS_START, C_vsync_pulse);
        sof    = (cx_q == '0) && (cy_q == '0);

        cx_d = cx_q + 1'b1;
        cy_d = cy_q;
        if (cx_q == X_LAST) begin
            cx_d = '0;
            cy_d = (cy_q == Y_LAST) ? '0 : cy_q + 1'b1;
        end

        fc_d     = sof ? fc_q + 16'd1 : fc_q;
        active_d = active;
        rgb_d    = active ? {red_byte, green_byte, blue_byte} : '0;
        hsync_d  = hs_win ? HS_ON : ~HS_ON;
        // Vertical sync only changes at the start of a line so it stays aligned with hsync.
        vsync_d  = (cx_q == '0) ? (vs_win ? VS_ON : ~VS_ON) : vsync_q;
        vblank_d = (cy_q >= Y_RES);
        tp_d     = test_picture;
    end

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            cx_q     <= '0;
            cy_q     <= '0;
            fc_q     <= '0;
            active_q <= 1'b0;
            rgb_q    <= '0;
            hsync_q  <= ~HS_ON;
            vsync_q  <= ~VS_ON;
            vblank_q <= 1'b0;
            tp_q     <= 1'b0;
        end else begin
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            fc_q     <= fc_d;
            active_q <= active_d;
            rgb_q    <= rgb_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            vblank_q <= vblank_d;
            tp_q     <= tp_d;
        end
    end

`ifdef VGA_VIDEO_GEN_TEST_PICTURE_EN
    vga_test_pattern #(
        .C_bits_x     (C_bits_x),
        .C_bits_y     (C_bits_y),
        .C_bits_color (C_bits_color)
    ) u_test_pattern (
        .clk_pixel   (clk_pixel),
        .reset_n     (reset_n),
        .beam_x      (cx_q),
        .beam_y      (cy_q),
        .frame_count (fc_q),
        .pat_r       (pat.r),
        .pat_g       (pat.g),
        .pat_b       (pat.b)
    );
    assign use_pat = tp_q;
`else
    // Without the pattern generator test_picture has no effect on the output.
    assign pat     = '0;
    assign use_pat = tp_q & 1'b0;
`endif

    // FIFO colour is already zeroed outside the active area; the pattern is gated here.
    always_comb begin
        pix = rgb_q;
        if (use_pat && active_q) begin
            pix = pat;
        end
    end

    assign vga_r       = pix.r;
    assign vga_g       = pix.g;
    assign vga_b       = pix.b;
    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign vga_vblank  = vblank_q;
    assign vga_blank   = ~active_q;
    assign beam_x      = cx_q;
    assign beam_y      = cy_q;
    assign frame_count = fc_q;
    assign frame_start = reset_n && sof;
    assign fetch_next  = active && ((C_dbl_x == 0) || !cx_q[0]);
    assign line_repeat = (C_dbl_y != 0) && hs_win && !cy_q[0];

endmodule

// File: tb/tb_vga_video_gen.sv
// Bench for vga_video_gen on an 8x4 visible / 14x7 total frame, plus a pixel-doubling
// instance and a one-pixel-frame instance used to reach the 16-bit frame counter wrap.
module tb_vga_video_gen;

    localparam int RX = 8;
    localparam int RY = 4;
    localparam int FX = 14;
    localparam int FRAME = 98;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, reset_fc_n, test_picture;
    logic [7:0] red_byte, green_byte, blue_byte;

    logic        fetch_next, line_repeat, frame_start, vga_hsync, vga_vsync, vga_vblank, vga_blank;
    logic [11:0] beam_x;
    logic [10:0] beam_y;
    logic [15:0] frame_count;
    logic [7:0]  vga_r, vga_g, vga_b;

    logic        dx_fetch, dx_lrep, dx_fs, dx_hs, dx_vs, dx_vb, dx_bl;
    logic [11:0] dx_bx;
    logic [10:0] dx_by;
    logic [15:0] dx_fc;
    logic [7:0]  dx_r, dx_g, dx_b;

    logic        fc_fetch, fc_lrep, fc_fs, fc_hs, fc_vs, fc_vb, fc_bl;
    logic [11:0] fc_bx;
    logic [10:0] fc_by;
    logic [15:0] fc_count;
    logic [7:0]  fc_r, fc_g, fc_b;

    vga_video_gen #(
        .C_resolution_x(8), .C_hsync_front_porch(2), .C_hsync_pulse(2), .C_hsync_back_porch(2),
        .C_resolution_y(4), .C_vsync_front_porch(1), .C_vsync_pulse(1), .C_vsync_back_porch(1)
    ) dut (
        .clk_pixel(clk), .reset_n(reset_n), .test_picture(test_picture),
        .red_byte(red_byte), .green_byte(green_byte), .blue_byte(blue_byte),
        .fetch_next(fetch_next), .line_repeat(line_repeat), .beam_x(beam_x), .beam_y(beam_y),
        .frame_count(frame_count), .frame_start(frame_start),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vga_vblank(vga_vblank), .vga_blank(vga_blank)
    );

    vga_video_gen #(
        .C_resolution_x(8), .C_hsync_front_porch(2), .C_hsync_pulse(2), .C_hsync_back_porch(2),
        .C_resolution_y(4), .C_vsync_front_porch(1), .C_vsync_pulse(1), .C_vsync_back_porch(1),
        .C_dbl_x(1)
    ) dut_dx (
        .clk_pixel(clk), .reset_n(reset_n), .test_picture(test_picture),
        .red_byte(red_byte), .green_byte(green_byte), .blue_byte(blue_byte),
        .fetch_next(dx_fetch), .line_repeat(dx_lrep), .beam_x(dx_bx), .beam_y(dx_by),
        .frame_count(dx_fc), .frame_start(dx_fs),
        .vga_r(dx_r), .vga_g(dx_g), .vga_b(dx_b), .vga_hsync(dx_hs), .vga_vsync(dx_vs),
        .vga_vblank(dx_vb), .vga_blank(dx_bl)
    );

    vga_video_gen #(
        .C_resolution_x(1), .C_hsync_front_porch(0), .C_hsync_pulse(0), .C_hsync_back_porch(0),
        .C_resolution_y(1), .C_vsync_front_porch(0), .C_vsync_pulse(0), .C_vsync_back_porch(0)
    ) dut_fc (
        .clk_pixel(clk), .reset_n(reset_fc_n), .test_picture(test_picture),
        .red_byte(red_byte), .green_byte(green_byte), .blue_byte(blue_byte),
        .fetch_next(fc_fetch), .line_repeat(fc_lrep), .beam_x(fc_bx), .beam_y(fc_by),
        .frame_count(fc_count), .frame_start(fc_fs),
        .vga_r(fc_r), .vga_g(fc_g), .vga_b(fc_b), .vga_hsync(fc_hs), .vga_vsync(fc_vs),
        .vga_vblank(fc_vb), .vga_blank(fc_bl)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic [7:0] red;
        logic [7:0] exp_r;
        logic       exp_hs;
        logic       exp_blank;
    } vec_t;

    // Reference geometry: position within the frame for cycle n after reset release.
    function automatic int mx(input int n); return (n % FRAME) % FX; endfunction
    function automatic int my(input int n); return (n % FRAME) / FX; endfunction
    function automatic bit mact(input int n); return (mx(n) < RX) && (my(n) < RY); endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int ncyc);
        reset_n = 1'b0;
        repeat (ncyc) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
    endtask

    task automatic fc_proc();
        reset_fc_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_fc_n = 1'b1;
        @(negedge clk);
        chk("fc_start", 32'(fc_count), 32'd0);
        chk("fc_sof", 32'(fc_fs), 32'd1);
        repeat (65535) @(posedge clk);
        @(negedge clk);
        chk("fc_ffff", 32'(fc_count), 32'hffff);
        @(posedge clk);
        @(negedge clk);
        chk("fc_wrap16", 32'(fc_count), 32'd0);
    endtask

    task automatic main_proc();
        vec_t       tbl[$];
        int         cnt;
        logic [13:0] mask;
        logic [7:0] r_h, g_h, b_h, nr, ng, nb;
        bit         ap;

        // Reset held: outputs at reset values.
        reset_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_beam_x", 32'(beam_x), 32'd0);
        chk("rst_beam_y", 32'(beam_y), 32'd0);
        chk("rst_vga_r", 32'(vga_r), 32'd0);
        chk("rst_hsync", 32'(vga_hsync), 32'd1);
        chk("rst_vsync", 32'(vga_vsync), 32'd1);
        chk("rst_blank", 32'(vga_blank), 32'd1);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
        @(negedge clk);
        chk("rel_frame_start", 32'(frame_start), 32'd1);
        chk("rel_beam_x", 32'(beam_x), 32'd0);
        chk("rel_beam_y", 32'(beam_y), 32'd0);

        // Directed vectors: drive red in cycle .cyc, check outputs in the next cycle.
        tbl.push_back('{0,  8'hA5, 8'hA5, 1'b1, 1'b0});
        tbl.push_back('{7,  8'hA5, 8'hA5, 1'b1, 1'b0});
        tbl.push_back('{8,  8'hA5, 8'h00, 1'b1, 1'b1});
        tbl.push_back('{9,  8'h5A, 8'h00, 1'b1, 1'b1});
        tbl.push_back('{10, 8'h5A, 8'h00, 1'b0, 1'b1});
        tbl.push_back('{11, 8'h5A, 8'h00, 1'b0, 1'b1});
        tbl.push_back('{12, 8'h5A, 8'h00, 1'b1, 1'b1});
        tbl.push_back('{14, 8'h3C, 8'h3C, 1'b1, 1'b0});
        tbl.push_back('{21, 8'h96, 8'h96, 1'b1, 1'b0});
        tbl.push_back('{24, 8'h77, 8'h00, 1'b0, 1'b1});
        tbl.push_back('{56, 8'hFF, 8'h00, 1'b1, 1'b1});
        tbl.push_back('{60, 8'hFF, 8'h00, 1'b1, 1'b1});
        foreach (tbl[i]) begin
            while (cyc < tbl[i].cyc) step();
            red_byte = tbl[i].red;
            step();
            @(negedge clk);
            chk($sformatf("vec%0d_vga_r", i), 32'(vga_r), 32'(tbl[i].exp_r));
            chk($sformatf("vec%0d_hsync", i), 32'(vga_hsync), 32'(tbl[i].exp_hs));
            chk($sformatf("vec%0d_blank", i), 32'(vga_blank), 32'(tbl[i].exp_blank));
        end

        // Frame wrap after 98 cycles.
        while (cyc < FRAME) step();
        @(negedge clk);
        chk("wrap_beam_x", 32'(beam_x), 32'd0);
        chk("wrap_beam_y", 32'(beam_y), 32'd0);
        chk("wrap_frame_start", 32'(frame_start), 32'd1);
        chk("wrap_frame_count", 32'(frame_count), 32'd1);

        // Pixel doubling: one pop per pixel pair over a whole line.
        cnt = 0;
        mask = '0;
        for (int i = 0; i < FX; i++) begin
            if (i > 0) begin
                step();
                @(negedge clk);
            end
            if (dx_fetch) begin
                cnt++;
                mask[i] = 1'b1;
            end
        end
        chk("dblx_count", 32'(cnt), 32'd4);
        chk("dblx_positions", 32'(mask), 32'h0055);

        // Random colour stream against the frame model.
        do_reset(2);
        r_h = '0; g_h = '0; b_h = '0;
        for (int n = 0; n < 420; n++) begin
            nr = 8'($urandom);
            ng = 8'($urandom);
            nb = 8'($urandom);
            red_byte = nr;
            green_byte = ng;
            blue_byte = nb;
`ifdef VGA_VIDEO_GEN_TEST_PICTURE_EN
            test_picture = 1'b0;
`else
            test_picture = 1'($urandom);
`endif
            @(negedge clk);
            ap = (n >= 1) && mact(n - 1);
            chk("rnd_beam_x", 32'(beam_x), 32'(mx(n)));
            chk("rnd_beam_y", 32'(beam_y), 32'(my(n)));
            chk("rnd_frame_start", 32'(frame_start), 32'((mx(n) == 0) && (my(n) == 0)));
            chk("rnd_frame_count", 32'(frame_count), 32'(16'((n + FRAME - 1) / FRAME)));
            chk("rnd_fetch", 32'(fetch_next), 32'(mact(n)));
            chk("rnd_fetch_dblx", 32'(dx_fetch), 32'(mact(n) && (mx(n) % 2 == 0)));
            chk("rnd_line_repeat", 32'(line_repeat), 32'd0);
            chk("rnd_vga_r", 32'(vga_r), ap ? 32'(r_h) : 32'd0);
            chk("rnd_vga_g", 32'(vga_g), ap ? 32'(g_h) : 32'd0);
            chk("rnd_vga_b", 32'(vga_b), ap ? 32'(b_h) : 32'd0);
            chk("rnd_blank", 32'(vga_blank), 32'(!ap));
            chk("rnd_hsync", 32'(vga_hsync), 32'(!((n >= 1) && (mx(n - 1) == 10 || mx(n - 1) == 11))));
            chk("rnd_vsync", 32'(vga_vsync), 32'(!((n >= 1) && (my(n - 1) == 5))));
            chk("rnd_vblank", 32'(vga_vblank), 32'((n >= 1) && (my(n - 1) >= 4)));
            r_h = nr; g_h = ng; b_h = nb;
            step();
        end
        test_picture = 1'b0;

        // Reset asserted mid-frame at x=5, y=2.
        for (int i = 0; i < FRAME && !(mx(cyc) == 5 && my(cyc) == 2); i++) step();
        @(negedge clk);
        chk("mid_pre_beam_x", 32'(beam_x), 32'd5);
        chk("mid_pre_beam_y", 32'(beam_y), 32'd2);
        reset_n = 1'b0;
        step();
        @(negedge clk);
        chk("mid_beam_x", 32'(beam_x), 32'd0);
        chk("mid_beam_y", 32'(beam_y), 32'd0);
        chk("mid_blank", 32'(vga_blank), 32'd1);
        chk("mid_vga_r", 32'(vga_r), 32'd0);
        do_reset(1);
        @(negedge clk);
        chk("mid_rel_frame_start", 32'(frame_start), 32'd1);

`ifndef VGA_VIDEO_GEN_TEST_PICTURE_EN
        // Without the pattern generator the FIFO data is shown even with test_picture set.
        test_picture = 1'b1;
        red_byte = 8'h5A;
        step();
        @(negedge clk);
        chk("tp_ignored_vga_r", 32'(vga_r), 32'h5A);
        test_picture = 1'b0;
`endif
    endtask

    initial begin
        reset_n = 1'b0;
        reset_fc_n = 1'b0;
        test_picture = 1'b0;
        red_byte = 8'h00;
        green_byte = 8'h11;
        blue_byte = 8'h22;
        fork
            fc_proc();
            main_proc();
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
